move_input_conditioner: RTL and testbench

- Upstream stage of the game FSM. Converts four raw, bouncy, active-low board pushbuttons into clean, mutually exclusive direction levels `mov_right`, `mov_left`, `mov_up` and `mov_down`.
- The FSM registers one move on each 1->0 transition of a level (button release). This block therefore guarantees exactly one clean high pulse per physical press, and at most one direction high at any time.
- Contents: a 2-flop synchronizer, a per-button debounce counter, and a priority/lockout arbiter FSM.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/move_input_conditioner_if.sv | 24 ++
 rtl/debounce_channel.sv | 54 +++++
 rtl/move_input_conditioner.sv | 79 +++++++
 tb/tb_move_input_conditioner.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared direction/arbiter types and key bit indices
// Contents:
//   dir_t        - move direction, encoding matches the game FSM move decode
//   arb_state_t  - button arbiter states
//   KEY_*        - bit positions of each button in key_n / db
//   pick_owner   - highest-priority pressed button (right > left > up > down)
package game_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } arb_state_t;

    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;

    // Only meaningful when at least one bit of db is set; DOWN is the
    // fall-through so the caller must gate with |db.
    function automatic dir_t pick_owner(input logic [3:0] db);
        if (db[KEY_RIGHT])
            return RIGHT;
        else if (db[KEY_LEFT])
            return LEFT;
        else if (db[KEY_UP])
            return UP;
        else
            return DOWN;
    endfunction

endpackage

// File: rtl/move_input_conditioner_if.sv
// rtl/move_input_conditioner_if.sv - button input / clean direction output bundle
// Signals:
//   key_n[3:0]  raw active-low buttons (0 right, 1 left, 2 up, 3 down)
//   mov_*       clean, mutually exclusive direction levels
//   key_active  high while the arbiter is not idle
// Modports: master drives key_n (board/bench side), slave is the conditioner.
interface move_input_conditioner_if;
    logic [3:0] key_n;
    logic       mov_right;
    logic       mov_left;
    logic       mov_up;
    logic       mov_down;
    logic       key_active;

    modport master (
        output key_n,
        input  mov_right, mov_left, mov_up, mov_down, key_active
    );

    modport slave (
        input  key_n,
        output mov_right, mov_left, mov_up, mov_down, key_active
    );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - 2-flop synchronizer plus debounce counter for one button
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   key_n  in   raw active-low button
//   db     out  debounced level, 1 = pressed
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             raw;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to "released" so a key held through reset is
    // seen as a fresh press once reset lifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign raw = ~sync2;

    // The counter tracks consecutive cycles of disagreement; it is cleared
    // on acceptance, so it never reaches a wrap value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (raw == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - debounced, mutually exclusive direction levels from raw buttons
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   bus    slave modport: key_n in, mov_right/left/up/down and key_active out
// Structure: four debounce_channel instances feed an IDLE/HELD/LOCKOUT
// arbiter. Only the first-accepted (highest-priority) button owns the
// outputs; others are ignored until every button is released.
module move_input_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                      clk,
    input  logic                      reset,
    move_input_conditioner_if.slave   bus
);

    logic [3:0] db;

    for (genvar i = 0; i < 4; i++) begin : g_db
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_channel (
            .clk   (clk),
            .reset (reset),
            .key_n (bus.key_n[i]),
            .db    (db[i])
        );
    end

    arb_state_t state_q, state_d;
    dir_t       owner_q, owner_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= RIGHT;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (|db) begin
                    state_d = HELD;
                    owner_d = pick_owner(db);
                end
            end
            HELD: begin
                // Owner bit is already 0 here, so |db means another button
                // is still down and must not be promoted.
                if (!db[owner_q])
                    state_d = (|db) ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (db == 4'b0000)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded purely from flops, so outputs are glitch-free and drop
    // together with the asynchronous reset.
    always_comb begin
        bus.mov_right  = (state_q == HELD) && (owner_q == RIGHT);
        bus.mov_left   = (state_q == HELD) && (owner_q == LEFT);
        bus.mov_up     = (state_q == HELD) && (owner_q == UP);
        bus.mov_down   = (state_q == HELD) && (owner_q == DOWN);
        bus.key_active = (state_q != IDLE);
    end

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb/tb_move_input_conditioner.sv - scoreboard bench for move_input_conditioner
module tb_move_input_conditioner;

    localparam int DB_CYC  = 4;
    localparam int LATENCY = 2 + DB_CYC + 1;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
        string      tag;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    logic [4:0] prev_vec = '0;
    exp_t sb[$];

    move_input_conditioner_if bus();

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(DB_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // {key_active, mov_down, mov_up, mov_left, mov_right}
    function automatic logic [4:0] out_vec();
        return {bus.key_active, bus.mov_down, bus.mov_up, bus.mov_left, bus.mov_right};
    endfunction

    task automatic push_exp(input int c, input logic [4:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Change key_n just after a falling edge; an expected output change is
    // due LATENCY rising edges later.
    task automatic drive(input logic [3:0] k, input bit expect_change,
                         input logic [4:0] v, input string tag);
        @(negedge clk);
        bus.key_n = k;
        if (expect_change)
            push_exp(cyc + LATENCY, v, tag);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every output transition must match the head of the scoreboard, both
    // in value and in the cycle it appears.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [4:0] v;
            v = out_vec();
            check_eq("onehot0", 32'($onehot0(v[3:0])), 32'd1);
            if (v !== prev_vec) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_change", 32'(v), 32'(prev_vec));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
                    check_eq({e.tag, "_val"}, 32'(v), 32'(e.vec));
                end
                prev_vec = v;
            end
        end
    end

    initial begin
        bus.key_n = 4'b1111;

        // 1. reset
        #1 reset = 1'b1;
        #1 check_eq("reset_async_outs", 32'(out_vec()), 32'd0);
        wait_neg(3);
        check_eq("reset_held_outs", 32'(out_vec()), 32'd0);
        reset    = 1'b0;
        prev_vec = 5'b0;
        mon_en   = 1'b1;
        wait_neg(50);
        check_eq("idle_50_outs", 32'(out_vec()), 32'd0);

        // 2. right press and release
        drive(4'b1110, 1'b1, 5'b10001, "right_press");
        wait_neg(20);
        check_eq("right_held", 32'(bus.mov_right), 32'd1);
        drive(4'b1111, 1'b1, 5'b00000, "right_release");
        wait_neg(15);

        // 3. short glitch on left
        drive(4'b1101, 1'b0, 5'b0, "");
        wait_neg(2);
        drive(4'b1111, 1'b0, 5'b0, "");
        wait_neg(15);
        check_eq("glitch_no_active", 32'(bus.key_active), 32'd0);

        // 4. bouncing up, then stable low
        for (int i = 0; i < 10; i++) begin
            drive(bus.key_n ^ 4'b0100, 1'b0, 5'b0, "");
            wait_neg(1);
        end
        drive(4'b1011, 1'b1, 5'b10100, "up_after_bounce");
        wait_neg(20);
        drive(4'b1111, 1'b1, 5'b00000, "up_release");
        wait_neg(15);

        // 5. simultaneous right+up, lockout, then a fresh up press
        drive(4'b1010, 1'b1, 5'b10001, "right_up_press");
        wait_neg(20);
        drive(4'b1011, 1'b1, 5'b10000, "right_rel_lockout");
        wait_neg(20);
        check_eq("lockout_no_up", 32'(bus.mov_up), 32'd0);
        drive(4'b1111, 1'b1, 5'b00000, "lockout_exit");
        wait_neg(15);
        drive(4'b1011, 1'b1, 5'b10100, "up_repress");
        wait_neg(20);
        drive(4'b1111, 1'b1, 5'b00000, "up_rerelease");
        wait_neg(15);

        // 6. reset in the middle of a left press
        drive(4'b1101, 1'b1, 5'b10010, "left_press");
        wait_neg(15);
        @(posedge clk);
        #2;
        check_eq("left_before_reset", 32'(bus.mov_left), 32'd1);
        push_exp(cyc, 5'b00000, "reset_drop");
        reset = 1'b1;
        #1 check_eq("reset_mid_outs", 32'(out_vec()), 32'd0);
        wait_neg(3);
        reset = 1'b0;
        push_exp(cyc + LATENCY, 5'b10010, "left_rearm");
        wait_neg(20);
        drive(4'b1111, 1'b1, 5'b00000, "left_release");
        wait_neg(15);

        for (int i = 0; i < 100 && sb.size() != 0; i++)
            @(negedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
